graph_inst_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single graph draw path between the 8 instrument channels.

---
 rtl/graph_inst_arbiter.sv | 159 +++++++++++++++
 tb/tb_graph_inst_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/graph_inst_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// graph_inst_arbiter
//   Round-robin arbiter that shares the single graph draw path between the
//   eight instrument channels. The winning channel's {instrument, pitch} is
//   latched and offered to the graph writer on a valid/ready handshake. An
//   accepted offer is acknowledged to its requester with a one-cycle ack
//   pulse. An offer that stalls for TIMEOUT cycles is retired with a
//   one-cycle drop pulse and no ack.
//
// Parameters
//   PITCH_W   width of each channel's pitch index
//   TIMEOUT   OFFER cycles without out_ready before the offer is dropped
//             (0 disables the timeout)
//
// Ports
//   Clk        in   system clock, rising edge
//   Reset      in   synchronous, active-high
//   req        in   per-instrument request level, bit i = instrument i
//   pitch      in   per-instrument pitch, slice i = pitch[i*PITCH_W +: PITCH_W]
//   pause      in   blocks new grants, never aborts a pending offer
//   out_ready  in   graph writer accepts the current offer
//   out_valid  out  offer present
//   out_inst   out  granted instrument index
//   out_pitch  out  latched pitch of the granted instrument
//   ack        out  one-hot, one-cycle pulse to the accepted requester
//   drop       out  one-cycle pulse, offer retired by timeout
// -----------------------------------------------------------------------------
module graph_inst_arbiter #(
  parameter int PITCH_W = 7,
  parameter int TIMEOUT = 255
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [7:0]           req,
  input  logic [8*PITCH_W-1:0] pitch,
  input  logic                 pause,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [2:0]           out_inst,
  output logic [PITCH_W-1:0]   out_pitch,
  output logic [7:0]           ack,
  output logic                 drop
);

  // Counter is sized for TIMEOUT; keep at least one bit when the timeout is off.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  logic [0:0]         state_q,     state_d;
  logic [2:0]         rr_ptr_q,    rr_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [2:0]         out_inst_q,  out_inst_d;
  logic [PITCH_W-1:0] out_pitch_q, out_pitch_d;
  logic [7:0]         ack_q,       ack_d;
  logic               drop_q,      drop_d;
  logic [CNT_W-1:0]   tmo_cnt_q,   tmo_cnt_d;

  logic [7:0] elig_s;
  logic [2:0] winner_s;
  logic       found_s;
  logic [2:0] idx_s;

  // Round-robin search: first eligible channel starting at rr_ptr, wrapping 7->0.
  always_comb begin
    // The channel acked this cycle sits out one cycle so others get a turn.
    elig_s   = req & ~ack_q;
    winner_s = 3'd0;
    found_s  = 1'b0;
    idx_s    = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx_s    = rr_ptr_q + 3'(k);
      winner_s = (!found_s && elig_s[idx_s]) ? idx_s : winner_s;
      found_s  = found_s | elig_s[idx_s];
    end
  end

  // Next-state logic for the IDLE/OFFER handshake, timeout and pointer update.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pitch_d = out_pitch_q;
    ack_d       = 8'h00;
    drop_d      = 1'b0;
    tmo_cnt_d   = tmo_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!pause && found_s) begin
          state_d     = S_OFFER;
          out_valid_d = 1'b1;
          out_inst_d  = winner_s;
          out_pitch_d = pitch[int'(winner_s) * PITCH_W +: PITCH_W];
          tmo_cnt_d   = {CNT_W{1'b0}};
        end else begin
          out_valid_d = 1'b0;
        end
      end
      S_OFFER: begin
        // Offer fields are frozen here; req/pitch/pause changes are ignored.
        if (out_valid_q && out_ready) begin
          ack_d       = 8'h01 << out_inst_q;
          out_valid_d = 1'b0;
          rr_ptr_d    = out_inst_q + 3'd1;
          state_d     = S_IDLE;
        end else if ((TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST)) begin
          drop_d      = 1'b1;
          out_valid_d = 1'b0;
          rr_ptr_d    = out_inst_q + 3'd1;
          state_d     = S_IDLE;
        end else if (tmo_cnt_q != CNT_MAX) begin
          tmo_cnt_d = tmo_cnt_q + CNT_ONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset discards any offer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 3'd0;
      out_valid_q <= 1'b0;
      out_inst_q  <= 3'd0;
      out_pitch_q <= {PITCH_W{1'b0}};
      ack_q       <= 8'h00;
      drop_q      <= 1'b0;
      tmo_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pitch_q <= out_pitch_d;
      ack_q       <= ack_d;
      drop_q      <= drop_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_pitch = out_pitch_q;
  assign ack       = ack_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_graph_inst_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for graph_inst_arbiter: stimulus pushes expected events
// (offer start, transfer, ack, drop) stamped with the cycle they must appear
// in; a separate monitor pops and compares whatever the DUT presents.
module tb_graph_inst_arbiter;

  localparam int PW = 7;
  localparam int K_OFFER = 0;
  localparam int K_XFER  = 1;
  localparam int K_ACK   = 2;
  localparam int K_DROP  = 3;

  typedef struct {
    int          kind;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  logic          Clk;
  logic          Reset;
  logic [7:0]    req;
  logic [8*PW-1:0] pitch;
  logic          pause;
  logic          out_ready;
  logic          out_valid;
  logic [2:0]    out_inst;
  logic [PW-1:0] out_pitch;
  logic [7:0]    ack;
  logic          drop;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  graph_inst_arbiter #(.PITCH_W(PW), .TIMEOUT(4)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .pitch(pitch), .pause(pause),
    .out_ready(out_ready), .out_valid(out_valid), .out_inst(out_inst),
    .out_pitch(out_pitch), .ack(ack), .drop(drop)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] pv(input int i);
    logic [PW-1:0] v;
    v = (i == 3) ? 7'd60 : 7'(13 * i + 2);
    return v;
  endfunction

  function automatic logic [15:0] od(input int i);
    return {6'd0, 3'(i), pv(i)};
  endfunction

  function automatic logic [15:0] ad(input int i);
    logic [7:0] v;
    v = 8'h01 << i;
    return {8'h00, v};
  endfunction

  task automatic push(input int kind, input logic [15:0] data, input int at);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic see(input int kind, input logic [15:0] data);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d data=%h cyc=%0d, want no event", kind, data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data !== data || e.cyc != cyc) begin
        bad++;
        $display("FAIL event: got kind=%0d data=%h cyc=%0d, want kind=%0d data=%h cyc=%0d",
                 kind, data, cyc, e.kind, e.data, e.cyc);
      end
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Monitor: sample outputs on the falling edge and compare against the queue.
  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge Clk);
      if (out_valid === 1'b1 && !prev_valid) see(K_OFFER, {6'd0, out_inst, out_pitch});
      if (out_valid === 1'b1 && out_ready === 1'b1) see(K_XFER, {6'd0, out_inst, out_pitch});
      if (ack !== 8'h00) see(K_ACK, {8'h00, ack});
      if (drop !== 1'b0) see(K_DROP, 16'h0000);
      prev_valid = (out_valid === 1'b1);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    Reset = 1'b1; req = 8'h00; pause = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) pitch[i*PW +: PW] = pv(i);
    steps(3);
    check("rst_valid", {15'd0, out_valid}, 16'h0000);
    check("rst_inst",  {13'd0, out_inst}, 16'h0000);
    check("rst_pitch", {9'd0, out_pitch}, 16'h0000);
    check("rst_ack",   {8'd0, ack}, 16'h0000);
    check("rst_drop",  {15'd0, drop}, 16'h0000);
    Reset = 1'b0;
    step();

    // Single requester 3; request drops while the offer is pending.
    c = cyc; req = 8'h08; out_ready = 1'b1;
    push(K_OFFER, od(3), c + 1); push(K_XFER, od(3), c + 1); push(K_ACK, ad(3), c + 2);
    step(); req = 8'h00;
    steps(3);

    // All requesting: rr_ptr is 4, so 4,5,6,7,0,1,2,3,4,5 one grant per 2 cycles.
    c = cyc; req = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push(K_OFFER, od((4 + k) % 8), c + 1 + 2 * k);
      push(K_XFER,  od((4 + k) % 8), c + 1 + 2 * k);
      push(K_ACK,   ad((4 + k) % 8), c + 2 + 2 * k);
    end
    steps(20); req = 8'h00;
    steps(3);

    // rr_ptr=6, req=0x41: 6, 0 (wrap), 6.
    c = cyc; req = 8'h41;
    push(K_OFFER, od(6), c + 1); push(K_XFER, od(6), c + 1); push(K_ACK, ad(6), c + 2);
    push(K_OFFER, od(0), c + 3); push(K_XFER, od(0), c + 3); push(K_ACK, ad(0), c + 4);
    push(K_OFFER, od(6), c + 5); push(K_XFER, od(6), c + 5); push(K_ACK, ad(6), c + 6);
    steps(6); req = 8'h00;
    steps(3);

    // Timeout: inst 2 stalls, drop 4 cycles after offer; next grant skips to 3.
    c = cyc; req = 8'h04; out_ready = 1'b0;
    push(K_OFFER, od(2), c + 1);
    push(K_DROP, 16'h0000, c + 5);
    push(K_OFFER, od(3), c + 6); push(K_XFER, od(3), c + 6); push(K_ACK, ad(3), c + 7);
    step(); req = 8'h00;
    steps(4); req = 8'h0C; out_ready = 1'b1;
    step(); req = 8'h00;
    steps(3);

    // Pause blocks grants; release grants next cycle; pause during OFFER is ignored.
    c = cyc; pause = 1'b1; req = 8'h10; out_ready = 1'b1;
    push(K_OFFER, od(4), c + 5); push(K_XFER, od(4), c + 7); push(K_ACK, ad(4), c + 8);
    steps(4); pause = 1'b0;
    step(); pause = 1'b1; req = 8'h00; out_ready = 1'b0;
    steps(2); out_ready = 1'b1;
    step(); req = 8'h20;
    steps(3); req = 8'h00; pause = 1'b0;
    steps(2);

    // Reset mid-offer discards it and restores rr_ptr to 0.
    c = cyc; req = 8'h02; out_ready = 1'b0;
    push(K_OFFER, od(1), c + 1);
    step(); req = 8'h00;
    step(); Reset = 1'b1;
    step();
    check("midrst_valid", {15'd0, out_valid}, 16'h0000);
    check("midrst_ack",   {8'd0, ack}, 16'h0000);
    check("midrst_drop",  {15'd0, drop}, 16'h0000);
    check("midrst_inst",  {13'd0, out_inst}, 16'h0000);
    Reset = 1'b0;
    step();
    c = cyc; req = 8'h81; out_ready = 1'b1;
    push(K_OFFER, od(0), c + 1); push(K_XFER, od(0), c + 1); push(K_ACK, ad(0), c + 2);
    push(K_OFFER, od(7), c + 3); push(K_XFER, od(7), c + 3); push(K_ACK, ad(7), c + 4);
    steps(4); req = 8'h00;
    steps(4);

    check("queue_empty", 16'(exp_q.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
